// File: rtl/timer_device.sv
`timescale 1ns/1ps
// timer_device: memory-mapped tick timer with CNT, LIM and CTL registers,
// a free-running prescaler and a level interrupt (inta = READY & IE).
// Optional feature: define TIMER_DEVICE_OVERRUN_EN to implement CTL[2] OVERRUN.
module timer_device #(
    parameter int unsigned       DBITS     = 32,
    parameter logic [DBITS-1:0]  BASE_ADDR = 32'hF0000020,
    parameter int unsigned       TICK_DIV  = 10000,
    parameter logic [DBITS-1:0]  DEV_IDN   = 32'h1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] memAddrBus,
    input  logic             weBus,
    input  logic             reBus,
    input  logic [DBITS-1:0] dataBusOut,
    output logic [DBITS-1:0] dataBusIn,
    output logic             inta,
    output logic [DBITS-1:0] idn
);

    localparam int unsigned      PSC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);

    localparam logic [DBITS-1:0] ADDR_CNT = BASE_ADDR;
    localparam logic [DBITS-1:0] ADDR_LIM = BASE_ADDR + DBITS'(4);
    localparam logic [DBITS-1:0] ADDR_CTL = BASE_ADDR + DBITS'(8);

    logic [PSC_W-1:0] psc;
    logic [DBITS-1:0] cnt;
    logic [DBITS-1:0] lim;
    logic             ready;
    logic             ie;
    logic             overrun;

    logic             selCnt;
    logic             selLim;
    logic             selCtl;
    logic             wrCnt;
    logic             wrLim;
    logic             wrCtl;
    logic             tick;
    logic             limHit;
    logic             readySet;
    logic [DBITS-1:0] ctlVal;

    assign selCnt = (memAddrBus == ADDR_CNT);
    assign selLim = (memAddrBus == ADDR_LIM);
    assign selCtl = (memAddrBus == ADDR_CTL);
    assign wrCnt  = weBus & selCnt;
    assign wrLim  = weBus & selLim;
    assign wrCtl  = weBus & selCtl;

    assign tick   = (psc == PSC_LAST);
    // LIM=0 means free-run; the >= compare also catches a LIM lowered below CNT
    assign limHit = (lim != '0) && (cnt >= (lim - DBITS'(1)));
    // a CNT write in the same cycle swallows the tick, including its READY set
    assign readySet = tick & ~wrCnt & limHit;

    // prescaler: wraps every TICK_DIV cycles, restarted by a CNT write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc <= '0;
        end else if (wrCnt || tick) begin
            psc <= '0;
        end else begin
            psc <= psc + PSC_W'(1);
        end
    end

    // counter: CPU write has priority, otherwise advance or restart on tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (wrCnt) begin
            cnt <= dataBusOut;
        end else if (tick) begin
            if (limHit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DBITS'(1);
            end
        end
    end

    // limit register: plain read/write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lim <= '0;
        end else if (wrLim) begin
            lim <= dataBusOut;
        end
    end

    // READY (hardware set beats write-0 clear) and IE (plain rw)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready <= 1'b0;
            ie    <= 1'b0;
        end else begin
            if (readySet) begin
                ready <= 1'b1;
            end else if (wrCtl && !dataBusOut[0]) begin
                ready <= 1'b0;
            end
            if (wrCtl) begin
                ie <= dataBusOut[4];
            end
        end
    end

`ifdef TIMER_DEVICE_OVERRUN_EN
    // OVERRUN: set when READY is re-set while still pending; set beats clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (readySet && ready) begin
            overrun <= 1'b1;
        end else if (wrCtl && !dataBusOut[2]) begin
            overrun <= 1'b0;
        end
    end
`else
    assign overrun = 1'b0;
`endif

    // CTL read view: unimplemented bits read as zero
    always_comb begin
        ctlVal    = '0;
        ctlVal[0] = ready;
        ctlVal[2] = overrun;
        ctlVal[4] = ie;
    end

    // zero-latency read mux; zero when unselected so the bus can be OR-ed
    always_comb begin
        dataBusIn = '0;
        if (reBus) begin
            if (selCnt) begin
                dataBusIn = cnt;
            end else if (selLim) begin
                dataBusIn = lim;
            end else if (selCtl) begin
                dataBusIn = ctlVal;
            end
        end
    end

    assign inta = ready & ie;
    assign idn  = inta ? DEV_IDN : '0;

endmodule
